// File: rtl/fifo_write_arbiter_if.sv
// rtl/fifo_write_arbiter_if.sv - producer/FIFO-side signal bundle for fifo_write_arbiter
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(DEPTH) + 1;

  logic [NUM_REQ-1:0]       req_valid_in;
  logic [NUM_REQ-1:0]       req_last_in;
  logic [NUM_REQ*WIDTH-1:0] req_data_in;
  logic [NUM_REQ-1:0]       req_ready_out;
  logic                     fifo_wr_en_out;
  logic [IDW+WIDTH-1:0]     fifo_data_out;
  logic                     credit_return_in;
  logic [CW-1:0]            credits_out;
  logic                     busy_out;
  logic                     credit_err_out;

  modport slave (
    input  req_valid_in, req_last_in, req_data_in, credit_return_in,
    output req_ready_out, fifo_wr_en_out, fifo_data_out, credits_out,
           busy_out, credit_err_out
  );

  modport master (
    output req_valid_in, req_last_in, req_data_in, credit_return_in,
    input  req_ready_out, fifo_wr_en_out, fifo_data_out, credits_out,
           busy_out, credit_err_out
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - packet round-robin arbiter sharing one FIFO write port
// Credits mirror FIFO free space; each written word carries its source ID.
module fifo_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8
) (
  input logic                clk_in,
  input logic                rst_in,
  fifo_write_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(DEPTH) + 1;

  typedef enum logic {ARB, BURST} state_t;

  state_t               state_q;
  logic [IDW-1:0]       lock_q;
  logic [IDW-1:0]       rr_ptr_q;
  logic [CW-1:0]        credits_q;
  logic                 wr_en_q;
  logic [IDW+WIDTH-1:0] data_q;
  logic                 busy_q;
  logic                 err_q;

  logic [NUM_REQ-1:0]   ready_d;
  logic [IDW-1:0]       winner_d;
  logic                 grant_d;
  logic [IDW-1:0]       next_ptr_d;
  logic                 last_d;
  logic [WIDTH-1:0]     payload_d;

  always_comb begin
    int idx;
    idx      = 0;
    ready_d  = '0;
    winner_d = lock_q;
    grant_d  = 1'b0;
    if (!rst_in && credits_q != '0) begin
      if (state_q == BURST) begin
        grant_d = bus.req_valid_in[lock_q];
      end else begin
        // Scan from the farthest offset down so the nearest valid requester wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
          idx = int'(rr_ptr_q) + k;
          if (idx >= NUM_REQ) idx = idx - NUM_REQ;
          if (bus.req_valid_in[IDW'(idx)]) begin
            grant_d  = 1'b1;
            winner_d = IDW'(idx);
          end
        end
      end
      ready_d[winner_d] = grant_d;
    end
  end

  assign last_d     = bus.req_last_in[winner_d];
  assign payload_d  = bus.req_data_in[int'(winner_d)*WIDTH +: WIDTH];
  assign next_ptr_d = (winner_d == IDW'(NUM_REQ - 1)) ? '0 : winner_d + IDW'(1);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ARB;
      lock_q    <= '0;
      rr_ptr_q  <= '0;
      credits_q <= CW'(DEPTH);
      wr_en_q   <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q <= grant_d;
      if (grant_d) begin
        data_q <= {winner_d, payload_d};
        if (last_d) begin
          state_q  <= ARB;
          busy_q   <= 1'b0;
          rr_ptr_q <= next_ptr_d;
        end else begin
          state_q <= BURST;
          busy_q  <= 1'b1;
          lock_q  <= winner_d;
        end
      end
      // A simultaneous take and return cancel out.
      if (grant_d && !bus.credit_return_in) begin
        credits_q <= credits_q - CW'(1);
      end else if (!grant_d && bus.credit_return_in) begin
        if (credits_q == CW'(DEPTH)) err_q <= 1'b1;
        else credits_q <= credits_q + CW'(1);
      end
    end
  end

  assign bus.req_ready_out  = ready_d;
  assign bus.fifo_wr_en_out = wr_en_q;
  assign bus.fifo_data_out  = data_q;
  assign bus.credits_out    = credits_q;
  assign bus.busy_out       = busy_q;
  assign bus.credit_err_out = err_q;
endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares one write port of a downstream FIFO (WIDTH data, DEPTH entries) among NUM_REQ producers, e.g. CPU, DMA and PPU event streams.
- Producers use a valid/ready handshake.
- Grants are round-robin at packet granularity, with a burst lock until the producer's last beat.
- Internal credit counter mirrors FIFO free space, so the FIFO never sees a write while full; each word is tagged with its source ID.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
WIDTH, 8, payload width per requester
DEPTH, 8, downstream FIFO depth = initial credit count
IDW, $clog2(NUM_REQ), source-ID tag width (derived, localparam)

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-high reset
req_valid_in  input  NUM_REQ  per-requester data valid
req_last_in  input  NUM_REQ  per-requester last beat of packet
req_data_in  input  NUM_REQ*WIDTH  packed payloads; requester i at [i*WIDTH +: WIDTH]
req_ready_out  output  NUM_REQ  per-requester accept, combinational, one-hot or zero
fifo_wr_en_out  output  1  registered write strobe to FIFO
fifo_data_out  output  IDW+WIDTH  registered {source ID, payload}
credit_return_in  input  1  one-cycle pulse per word popped from FIFO
credits_out  output  $clog2(DEPTH)+1  current free-slot count
busy_out  output  1  high while in BURST state
credit_err_out  output  1  sticky: credit return seen at credits==DEPTH

Behaviour:
- Reset, asynchronous, any cycle including mid-burst:
  - state=ARB, rr_ptr=0, credits=DEPTH.
  - fifo_wr_en_out=0, fifo_data_out=0, busy_out=0, credit_err_out=0.
  - req_ready_out=0 while rst_in is high.
  - A partially sent packet is abandoned; no write is issued after reset.
- Transfer on requester i = req_valid_in[i] && req_ready_out[i]. At most one transfer per cycle.
- Grant, combinational. No grant when credits==0.
  - ARB: winner = first i with valid, searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ. req_ready_out[winner]=1.
  - BURST: only the locked requester L may be granted; ready[L]=valid[L]. Other requesters wait even if L is idle.
- State machine:
  - ARB -> BURST on a transfer with last=0; L := winner.
  - BURST -> ARB on a transfer from L with last=1.
  - ARB stays in ARB on a transfer with last=1 (single-beat packet).
- rr_ptr update:
  - On any transfer with last=1: rr_ptr := (winner+1) mod NUM_REQ. Wrap at NUM_REQ-1 -> 0, no power-of-two assumption.
  - Unchanged otherwise.
- Output path, latency 1:
  - The cycle after a transfer: fifo_wr_en_out=1, fifo_data_out={IDW'(winner), payload}.
  - fifo_wr_en_out=0 in cycles after no transfer; fifo_data_out holds its last value.
- Credits, updated on the transfer cycle, not the write cycle:
  - Transfer only: credits-1.
  - credit_return_in only: credits+1.
  - Both: unchanged.
  - A return when credits==DEPTH and no transfer leaves credits unchanged and sets credit_err_out.
  - credits never underflows, since grant is blocked at 0.
- busy_out = (state==BURST), registered.
- credits==0 mid-burst: lock retained; burst resumes when a credit returns.
- req_data_in and req_last_in are sampled only on the transfer cycle.

Test Plan:
- Reset, then all three requesters valid with last=1 and distinct data 0x11/0x22/0x33, held for 6 cycles -> writes in order {0,11},{1,22},{2,33},{0,11},{1,22},{2,33}. wr_en lags each grant by 1 cycle; credits 8->2.
- Requester 1 sends a 3-beat packet (last on beat 3) while 0 and 2 are continuously valid -> beats from 1 are contiguous; busy_out high for beats 2-3; requester 2 is granted next, then 0.
- No credit returns, requester 0 streams 10 single beats -> exactly 8 writes; credits_out=0; ready[0]=0. Then one credit_return_in pulse -> one more write; credits stays 0.
- Simultaneous transfer and credit_return_in at credits=5 -> credits stays 5. Return pulse at credits=8 with no transfer -> credits=8, credit_err_out=1 until reset.
- Assert rst_in asynchronously mid-cycle during a 4-beat burst after beat 2 -> outputs clear immediately, busy_out=0, credits=8. After release, a new request from requester 2 is granted first (rr_ptr=0 search, only 2 valid).
- NUM_REQ=5: requester 4 single beat, then requesters 0 and 4 valid -> requester 0 is granted next (pointer wraps 4->0).
